// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI slave.
//   spi_state_e    - FSM state encoding (IDLE=0, ACTIVE=1, WAIT_CS=2)
//   DATA_W_DEFAULT - default frame width in bits
`timescale 1ns/1ps
package spi_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    WAIT_CS = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: SYNC_STAGES-deep flip-flop synchronizer for one asynchronous bit.
// The chain presets high on reset, matching the idle level of cs.
//   clk   - system clock
//   reset - synchronous active-high reset (presets chain to 1)
//   d_i   - asynchronous input
//   q_o   - synchronized output
`timescale 1ns/1ps
module spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave, all modes (CPOL/CPHA), MSB first.
// spi_clk, cs and mosi are synchronized into clk; edges are found by
// comparing the last two synchronized samples.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   polarity, phase     - CPOL/CPHA, latched at frame start
//   spi_clk, cs, mosi   - master signals (cs active low)
//   miso, miso_oe       - slave data out and its output enable
//   tx_data, tx_load    - write port for the transmit buffer
//   rx_data, rx_valid   - received frame and 1-cycle strobe
//   state, count        - FSM state and bits received in the current frame
// Optional build macro SPI_SLAVE_OVERRUN_EN adds:
//   rx_ack              - clears the pending-frame flag
//   rx_overrun          - sticky: a frame completed while one was pending
`timescale 1ns/1ps
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              phase,
  input  logic              spi_clk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [1:0]        state,
  output logic [3:0]        count
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic              rx_ack,
  output logic              rx_overrun
`endif
);

  localparam logic [3:0] COUNT_FULL = 4'(DATA_W);
  // After reset the synchronizers read high regardless of the real cs, so
  // WAIT_CS ignores cs until the chains have refilled from the pins.
  localparam int               FLUSH_W = $clog2(SYNC_STAGES + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_N = FLUSH_W'(SYNC_STAGES + 1);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_prev_q, cs_prev_q;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .d_i(spi_clk), .q_o(sclk_s));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset(reset), .d_i(cs), .q_o(cs_s));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .d_i(mosi), .q_o(mosi_s));

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  spi_state_e         state_q;
  logic [3:0]         count_q;
  logic [DATA_W-1:0]  rx_shift_q, rx_data_q, tx_buf_q, tx_shift_q;
  logic               rx_valid_q, miso_q, cpol_q, cpha_q;
  logic [FLUSH_W-1:0] flush_q;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic [DATA_W-1:0] buf_next;

  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign cs_fall     = ~cs_s & cs_prev_q;
  assign cs_rise     = cs_s & ~cs_prev_q;
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  // A load coinciding with a frame-boundary reload goes straight to the shifter.
  assign buf_next    = tx_load ? tx_data : tx_buf_q;

  always_ff @(posedge clk) begin
    if (reset)        tx_buf_q <= '0;
    else if (tx_load) tx_buf_q <= tx_data;
  end

  // tx_shift_q holds the bits not yet driven onto miso; miso_q is the bit
  // currently driven. Each shift edge moves the next bit from one to the other.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_CS;
      count_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_shift_q <= '0;
      miso_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      flush_q    <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        WAIT_CS: begin
          if (flush_q != FLUSH_N) flush_q <= flush_q + 1'b1;
          else if (cs_s)          state_q <= IDLE;
        end
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            cpol_q  <= polarity;
            cpha_q  <= phase;
            count_q <= '0;
            state_q <= ACTIVE;
            if (phase) begin
              tx_shift_q <= tx_buf_q;
            end else begin
              // CPHA=0: first bit must already be on miso before the first edge.
              miso_q     <= tx_buf_q[DATA_W-1];
              tx_shift_q <= tx_buf_q << 1;
            end
          end
        end
        ACTIVE: begin
          if (count_q == COUNT_FULL) begin
            rx_data_q  <= rx_shift_q;
            rx_valid_q <= 1'b1;
            count_q    <= '0;
            tx_shift_q <= buf_next;
          end else begin
            if (sample_edge) begin
              rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
              count_q    <= count_q + 1'b1;
            end
            if (shift_edge) begin
              miso_q     <= tx_shift_q[DATA_W-1];
              tx_shift_q <= tx_shift_q << 1;
            end
          end
          if (cs_rise) begin
            state_q <= IDLE;
            count_q <= '0;
            miso_q  <= 1'b0;
          end
        end
        default: state_q <= WAIT_CS;
      endcase
    end
  end

  assign miso     = miso_q & ~cs_s;
  assign miso_oe  = ~cs_s;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign state    = state_q;
  assign count    = count_q;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic pending_q, overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (rx_valid_q) begin
        pending_q <= 1'b1;
        if (pending_q && !rx_ack) overrun_q <= 1'b1;
      end else if (rx_ack) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign rx_overrun = overrun_q;
`endif

endmodule
